// File: rtl/interrupt_sequencer_if.sv
// Bundle between the CPU core and the interrupt sequencer: request/status
// inputs flow from the core (master) and control strobes flow back from the
// sequencer (slave).
interface interrupt_sequencer_if;
    // Core -> sequencer
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic       instr_boundary;
    logic       brk_req;
    logic       rdy;
    // Sequencer -> core
    logic       busy;
    logic [2:0] seq_step;
    logic [1:0] int_type;
    logic       pc_inc;
    logic       push_pch;
    logic       push_pcl;
    logic       push_psr;
    logic       sp_dec;
    logic       brk_bit;
    logic       vec_fetch_lo;
    logic       vec_fetch_hi;
    logic       set_i;
    logic       pc_load;
    logic       seq_done;
    logic [7:0] vec_lo;

    modport master (
        output nmi_n, irq_n, i_flag, instr_boundary, brk_req, rdy,
        input  busy, seq_step, int_type, pc_inc, push_pch, push_pcl, push_psr, sp_dec,
               brk_bit, vec_fetch_lo, vec_fetch_hi, set_i, pc_load, seq_done, vec_lo
    );

    modport slave (
        input  nmi_n, irq_n, i_flag, instr_boundary, brk_req, rdy,
        output busy, seq_step, int_type, pc_inc, push_pch, push_pcl, push_psr, sp_dec,
               brk_bit, vec_fetch_lo, vec_fetch_hi, set_i, pc_load, seq_done, vec_lo
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt sequencer: accepts RESET/NMI/BRK/IRQ at instruction
// boundaries and walks a fixed six-step push/vector-fetch sequence.
module interrupt_sequencer #(
    parameter logic [7:0] NMI_VEC = 8'hFA,
    parameter logic [7:0] RST_VEC = 8'hFC,
    parameter logic [7:0] IRQ_VEC = 8'hFE
) (
    input logic            clk,
    input logic            nrst,
    interrupt_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        TypeIrq = 2'd0,
        TypeBrk = 2'd1,
        TypeNmi = 2'd2,
        TypeRst = 2'd3
    } int_type_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrep    = 3'd1,
        StPushPch = 3'd2,
        StPushPcl = 3'd3,
        StPushPsr = 3'd4,
        StVecLo   = 3'd5,
        StVecHi   = 3'd6
    } step_e;

    step_e     step_q, step_d;
    int_type_e int_type_q, int_type_d;
    logic      nmi_pending_q, nmi_pending_d;
    logic      nmi_sample_q;
    logic      reset_pending_q, reset_pending_d;

    logic      nmi_edge;
    logic      nmi_req;
    logic      nmi_clear;
    logic [7:0] base_vec;

    // Falling edge on the sampled NMI line; counts toward acceptance in the
    // same cycle so a coincident edge beats a level IRQ.
    assign nmi_edge = nmi_sample_q & ~bus.nmi_n;
    assign nmi_req  = nmi_pending_q | nmi_edge;

    // State registers; edge sampling runs every clock, even while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_q          <= StIdle;
            int_type_q      <= TypeRst;
            nmi_pending_q   <= 1'b0;
            nmi_sample_q    <= 1'b1;
            reset_pending_q <= 1'b1;
        end else begin
            step_q          <= step_d;
            int_type_q      <= int_type_d;
            nmi_pending_q   <= nmi_pending_d;
            nmi_sample_q    <= bus.nmi_n;
            reset_pending_q <= reset_pending_d;
        end
    end

    // Next-state: acceptance in idle, step advance on rdy, NMI hijack into step 5.
    always_comb begin
        step_d          = step_q;
        int_type_d      = int_type_q;
        reset_pending_d = reset_pending_q;
        nmi_clear       = 1'b0;
        if (bus.rdy) begin
            unique case (step_q)
                StIdle: begin
                    if (reset_pending_q) begin
                        step_d          = StPrep;
                        int_type_d      = TypeRst;
                        reset_pending_d = 1'b0;
                    end else if (bus.instr_boundary) begin
                        if (nmi_req) begin
                            step_d     = StPrep;
                            int_type_d = TypeNmi;
                        end else if (bus.brk_req) begin
                            step_d     = StPrep;
                            int_type_d = TypeBrk;
                        end else if (!bus.irq_n && !bus.i_flag) begin
                            step_d     = StPrep;
                            int_type_d = TypeIrq;
                        end
                    end
                end
                StPrep:    step_d = StPushPch;
                StPushPch: step_d = StPushPcl;
                StPushPcl: step_d = StPushPsr;
                StPushPsr: begin
                    step_d = StVecLo;
                    // A pending NMI steals an IRQ/BRK before its vector is fetched.
                    if ((int_type_q == TypeIrq || int_type_q == TypeBrk) && nmi_req) begin
                        int_type_d = TypeNmi;
                    end
                end
                StVecLo: begin
                    step_d    = StVecHi;
                    nmi_clear = (int_type_q == TypeNmi);
                end
                StVecHi: step_d = StIdle;
                default: step_d = StIdle;
            endcase
        end
        // A new edge wins over the clear so it is serviced at the next boundary.
        nmi_pending_d = (nmi_pending_q & ~nmi_clear) | nmi_edge;
    end

    // Vector base follows the (possibly hijacked) latched type.
    always_comb begin
        unique case (int_type_q)
            TypeNmi: base_vec = NMI_VEC;
            TypeRst: base_vec = RST_VEC;
            default: base_vec = IRQ_VEC;
        endcase
    end

    // Output decode: strobes gated by rdy, vec_lo purely by step.
    always_comb begin
        bus.pc_inc       = 1'b0;
        bus.push_pch     = 1'b0;
        bus.push_pcl     = 1'b0;
        bus.push_psr     = 1'b0;
        bus.sp_dec       = 1'b0;
        bus.brk_bit      = 1'b0;
        bus.vec_fetch_lo = 1'b0;
        bus.vec_fetch_hi = 1'b0;
        bus.set_i        = 1'b0;
        bus.pc_load      = 1'b0;
        bus.seq_done     = 1'b0;
        bus.vec_lo       = 8'h00;
        if (step_q == StVecLo) begin
            bus.vec_lo = base_vec;
        end else if (step_q == StVecHi) begin
            bus.vec_lo = base_vec | 8'h01;
        end
        if (bus.rdy) begin
            unique case (step_q)
                StPrep: bus.pc_inc = (int_type_q == TypeBrk);
                StPushPch: begin
                    bus.sp_dec   = 1'b1;
                    bus.push_pch = (int_type_q != TypeRst);
                end
                StPushPcl: begin
                    bus.sp_dec   = 1'b1;
                    bus.push_pcl = (int_type_q != TypeRst);
                end
                StPushPsr: begin
                    bus.sp_dec   = 1'b1;
                    bus.push_psr = (int_type_q != TypeRst);
                    bus.brk_bit  = (int_type_q == TypeBrk);
                end
                StVecLo: begin
                    bus.vec_fetch_lo = 1'b1;
                    bus.set_i        = 1'b1;
                end
                StVecHi: begin
                    bus.vec_fetch_hi = 1'b1;
                    bus.pc_load      = 1'b1;
                    bus.seq_done     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (step_q != StIdle);
    assign bus.seq_step = step_q;
    assign bus.int_type = int_type_q;

endmodule
